spi_frame_slave: RTL

//  Parametrised SPI slave (mode 0) frame engine for the stepper CPLD: N_CH channels.

---
 rtl/spi_frame_slave.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_slave.sv
// ---------------------------------------------------------------------------
// spi_frame_slave
//   SPI mode-0 slave frame engine for the stepper CPLD. One frame carries the
//   per-channel velocities, output pins and timing config from the host. The
//   same frame returns a coherent snapshot of positions, input pins and rpm.
//   Incoming data lands in shadow registers. The shadows are copied to the
//   outputs in a single cycle, and only when the frame was well formed. That
//   copy raises a one-cycle commit strobe, which feeds the watchdog kick.
//
//   Frame layout (FRAME_LEN = 4*N_CH+8 bytes; bytes are bit-MSB-first and
//   multi-byte fields are sent LSB byte first):
//     byte 0            MOSI cmd          MISO {last_ok,3'b0,err_cnt}
//     bytes 1..4*N_CH   MOSI vel[c]       MISO pos snapshot[c]
//     next 4            MOSI dout         MISO din
//     next 2            MOSI cfg          MISO rpm
//     last              MOSI chk          MISO two's complement checksum
//
// Ports
//   clk      in   system clock, at least 8x the SCK rate
//   rst_n    in   asynchronous active-low reset
//   sck      in   SPI clock (asynchronous, synchronised internally)
//   ssel     in   SPI select, active low (asynchronous, synchronised)
//   mosi     in   SPI data in, sampled on synchronised SCK rise
//   miso     out  SPI data out, MSB first, changes on synchronised SCK fall
//   pos      in   channel positions, ch0 in the LSBs
//   din      in   input pins
//   rpm      in   spindle rpm count
//   vel      out  committed velocities, ch0 in the LSBs
//   dout     out  committed output pins
//   cfg      out  committed timing config word, passed through as sent
//   commit   out  one-cycle pulse when the shadows are copied to the outputs
//   last_ok  out  1 when the most recent frame was valid
//   err_cnt  out  saturating count of rejected frames
// ---------------------------------------------------------------------------
module spi_frame_slave #(
  parameter int N_CH = 4,
  parameter int VW   = 12,
  parameter int PW   = 21,
  parameter int O    = 16,
  parameter int I    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sck,
  input  logic                ssel,
  input  logic                mosi,
  output logic                miso,
  input  logic [N_CH*PW-1:0]  pos,
  input  logic [I-1:0]        din,
  input  logic [15:0]         rpm,
  output logic [N_CH*VW-1:0]  vel,
  output logic [O-1:0]        dout,
  output logic [15:0]         cfg,
  output logic                commit,
  output logic                last_ok,
  output logic [3:0]          err_cnt
);

  localparam int FRAME_LEN = 4*N_CH + 8;
  localparam int IDX_DOUT  = 1 + 4*N_CH;
  localparam int IDX_CFG   = IDX_DOUT + 4;
  localparam int IDX_CHK   = FRAME_LEN - 1;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;

  state_t state;

  logic [3:0] sck_sync;
  logic [3:0] ssel_sync;
  logic [2:0] mosi_sync;
  logic       sck_rise;
  logic       sck_fall;
  logic       ssel_rise;
  logic       ssel_fall;
  logic       mosi_bit;

  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] rx_sum;
  logic [7:0] tx_shift;
  logic [7:0] tx_sum;
  logic [7:0] tx_next;
  logic       start_pending;
  logic       frame_ok;

  logic [N_CH*PW-1:0] pos_snap;
  logic [I-1:0]       din_snap;
  logic [15:0]        rpm_snap;

  logic [7:0] sh_byte  [FRAME_LEN];
  logic [7:0] tx_table [FRAME_LEN];

  logic [N_CH*VW-1:0] vel_next;
  logic [O-1:0]       dout_next;
  logic [15:0]        cfg_next;

  // Three flops bring each SPI pin into the clk domain. The fourth flop on
  // sck and ssel holds the previous synchronised value, for edge detection.
  // mosi is taken from the same stage as sck, so the data bit and its clock
  // edge stay aligned. All stages reset to 0. A select fall can therefore
  // only be seen after ssel has been observed high following reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ssel_sync <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[2:0], sck};
      ssel_sync <= {ssel_sync[2:0], ssel};
      mosi_sync <= {mosi_sync[1:0], mosi};
    end
  end

  assign sck_rise  =  sck_sync[2]  & ~sck_sync[3];
  assign sck_fall  = ~sck_sync[2]  &  sck_sync[3];
  assign ssel_rise =  ssel_sync[2] & ~ssel_sync[3];
  assign ssel_fall = ~ssel_sync[2] &  ssel_sync[3];
  assign mosi_bit  =  mosi_sync[2];

  assign rx_byte  = {rx_shift, mosi_bit};
  assign miso     = tx_shift[7];
  assign frame_ok = (byte_cnt == 8'(FRAME_LEN)) && (bit_cnt == 3'd0) &&
                    (rx_sum == 8'h00);

  // Reply bytes, built from the snapshot taken at frame start. The checksum
  // entry negates the running sum of the bytes already loaded, so the whole
  // reply sums to zero. Fields narrower than their byte slots are
  // zero-extended.
  always_comb begin
    for (int j = 0; j < FRAME_LEN; j++) begin
      tx_table[j] = 8'h00;
    end
    tx_table[0] = {last_ok, 3'b000, err_cnt};
    for (int c = 0; c < N_CH; c++) begin
      for (int b = 0; b < PW; b++) begin
        tx_table[1 + 4*c + b/8][b%8] = pos_snap[c*PW + b];
      end
    end
    for (int b = 0; b < I; b++) begin
      tx_table[IDX_DOUT + b/8][b%8] = din_snap[b];
    end
    tx_table[IDX_CFG]     = rpm_snap[7:0];
    tx_table[IDX_CFG + 1] = rpm_snap[15:8];
    tx_table[IDX_CHK]     = 8'h00 - tx_sum;
  end

  // The next reply byte is selected by the count of completed bytes. Any
  // count past the end of the frame selects 0x00.
  always_comb begin
    tx_next = 8'h00;
    for (int j = 0; j < FRAME_LEN; j++) begin
      if (byte_cnt == 8'(j)) begin
        tx_next = tx_table[j];
      end
    end
  end

  // Output words assembled from the shadow bytes. Velocity bits at or above
  // VW, and dout bits at or above O, are dropped.
  always_comb begin
    vel_next  = '0;
    dout_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int b = 0; b < VW; b++) begin
        vel_next[c*VW + b] = sh_byte[1 + 4*c + b/8][b%8];
      end
    end
    for (int b = 0; b < O; b++) begin
      dout_next[b] = sh_byte[IDX_DOUT + b/8][b%8];
    end
    cfg_next = {sh_byte[IDX_CFG + 1], sh_byte[IDX_CFG]};
  end

  // Frame engine. IDLE waits for select to fall. It then snapshots the
  // readback inputs and preloads the status byte. SHIFT moves bits until
  // select rises. EVAL spends one cycle deciding whether to commit. A select
  // fall that arrives during EVAL is remembered, and the new frame starts
  // from IDLE on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      rx_shift      <= '0;
      rx_sum        <= '0;
      tx_shift      <= '0;
      tx_sum        <= '0;
      start_pending <= 1'b0;
      pos_snap      <= '0;
      din_snap      <= '0;
      rpm_snap      <= '0;
      for (int j = 0; j < FRAME_LEN; j++) begin
        sh_byte[j] <= '0;
      end
      vel           <= '0;
      dout          <= '0;
      cfg           <= '0;
      commit        <= 1'b0;
      last_ok       <= 1'b0;
      err_cnt       <= '0;
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (ssel_fall || start_pending) begin
            state         <= SHIFT;
            start_pending <= 1'b0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            rx_shift      <= '0;
            rx_sum        <= '0;
            pos_snap      <= pos;
            din_snap      <= din;
            rpm_snap      <= rpm;
            tx_shift      <= tx_table[0];
            tx_sum        <= tx_table[0];
          end
        end

        SHIFT: begin
          if (ssel_rise) begin
            state <= EVAL;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_sum <= rx_sum + rx_byte;
                if (byte_cnt != 8'hFF) begin
                  byte_cnt <= byte_cnt + 8'd1;
                end
                for (int j = 0; j < FRAME_LEN; j++) begin
                  if (byte_cnt == 8'(j)) begin
                    sh_byte[j] <= rx_byte;
                  end
                end
              end
            end
            // The first fall after a byte completes loads the next reply
            // byte. Every other fall shifts the current byte out.
            if (sck_fall) begin
              if ((bit_cnt == 3'd0) && (byte_cnt != 8'd0)) begin
                tx_shift <= tx_next;
                tx_sum   <= tx_sum + tx_next;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
        end

        EVAL: begin
          state         <= IDLE;
          start_pending <= ssel_fall;
          tx_shift      <= '0;
          if (frame_ok && (sh_byte[0] == CMD_WRITE)) begin
            vel     <= vel_next;
            dout    <= dout_next;
            cfg     <= cfg_next;
            commit  <= 1'b1;
            last_ok <= 1'b1;
          end else if (frame_ok && (sh_byte[0] == CMD_READ)) begin
            last_ok <= 1'b1;
          end else begin
            last_ok <= 1'b0;
            if (err_cnt != 4'hF) begin
              err_cnt <= err_cnt + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
